// File: rtl/sha3_512_arbiter_pkg.sv
// Shared definitions for the SHA3-512 core arbiter: FSM encoding, datapath
// widths and the index-width helper used by the arbiter and its selector.
package sha3_512_arbiter_pkg;

  localparam int MSG_W = 256;
  localparam int DIG_W = 512;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_WAIT    = 2'b10,
    ST_DELIVER = 2'b11
  } state_e;

  // Index/pointer width; a single requester still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sha3_512_arbiter_rr_pick.sv
// Combinational round-robin selector: scans requests starting at the index
// just after the pointer and reports the first active one.
module rr_pick
  import sha3_512_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   pointer,
  output logic            found,
  output logic [IW-1:0]   index
);

  logic hit_s;

  // Priority scan in rotated order; the first hit locks the result.
  always_comb begin
    found = 1'b0;
    index = '0;
    hit_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      hit_s = ~found & req[(int'(pointer) + 1 + i) % NREQ];
      index = hit_s ? IW'((int'(pointer) + 1 + i) % NREQ) : index;
      found = found | hit_s;
    end
  end

endmodule

// File: rtl/sha3_512_arbiter.sv
// Round-robin arbiter sharing one SHA3-512 core among NREQ requesters, with a
// per-service timeout that ends a stuck service with an error flag.
module sha3_512_arbiter
  import sha3_512_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*MSG_W-1:0] msg,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic [DIG_W-1:0]      digest,
  output logic [MSG_W-1:0]      core_m,
  output logic                  core_active,
  input  logic                  core_finish,
  input  logic [DIG_W-1:0]      core_z
);

  localparam int IW = idx_width(NREQ);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [IW-1:0] PTR_RST  = IW'(NREQ - 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              err_q, err_d;
  logic [DIG_W-1:0]  digest_q, digest_d;
  logic [MSG_W-1:0]  core_m_q, core_m_d;
  logic              core_active_q, core_active_d;
  logic              pick_found_s;
  logic [IW-1:0]     pick_idx_s;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req     (req),
    .pointer (ptr_q),
    .found   (pick_found_s),
    .index   (pick_idx_s)
  );

  // Next-state and registered-output logic for the service FSM.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ptr_d         = ptr_q;
    tmr_d         = tmr_q;
    gnt_d         = gnt_q;
    done_d        = '0;
    err_d         = 1'b0;
    digest_d      = digest_q;
    core_m_d      = core_m_q;
    core_active_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d             = ST_ISSUE;
          idx_d               = pick_idx_s;
          core_m_d            = msg[pick_idx_s * MSG_W +: MSG_W];
          gnt_d               = '0;
          gnt_d[pick_idx_s]   = 1'b1;
          core_active_d       = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        tmr_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A finish in the expiry cycle takes precedence over the timeout.
        if (core_finish) begin
          digest_d      = core_z;
          done_d[idx_q] = 1'b1;
          state_d       = ST_DELIVER;
        end else if (tmr_q == TMO_LAST) begin
          done_d[idx_q] = 1'b1;
          err_d         = 1'b1;
          state_d       = ST_DELIVER;
        end else begin
          tmr_d = (tmr_q == {TW{1'b1}}) ? tmr_q : tmr_q + TMR_ONE;
        end
      end
      ST_DELIVER: begin
        ptr_d   = idx_q;
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset leaves requester 0 with first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      ptr_q         <= PTR_RST;
      tmr_q         <= '0;
      gnt_q         <= '0;
      done_q        <= '0;
      err_q         <= 1'b0;
      digest_q      <= '0;
      core_m_q      <= '0;
      core_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      ptr_q         <= ptr_d;
      tmr_q         <= tmr_d;
      gnt_q         <= gnt_d;
      done_q        <= done_d;
      err_q         <= err_d;
      digest_q      <= digest_d;
      core_m_q      <= core_m_d;
      core_active_q <= core_active_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign err         = err_q;
  assign digest      = digest_q;
  assign core_m      = core_m_q;
  assign core_active = core_active_q;

endmodule

// File: tb/tb_sha3_512_arbiter.sv
// Directed bench for sha3_512_arbiter with a behavioural core whose digest is
// a fixed reversible mix of the message it was issued.
module tb_sha3_512_arbiter;

  localparam int NREQ = 4;
  localparam int TMO  = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req = 4'b0000;
  logic [1023:0] msg = '0;
  logic [3:0]    gnt;
  logic [3:0]    done;
  logic          err;
  logic [511:0]  digest;
  logic [255:0]  core_m;
  logic          core_active;
  logic          core_finish;
  logic [511:0]  core_z;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int core_lat = 5;
  bit core_hang = 1'b0;
  int n_active = 0;

  sha3_512_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .msg         (msg),
    .gnt         (gnt),
    .done        (done),
    .err         (err),
    .digest      (digest),
    .core_m      (core_m),
    .core_active (core_active),
    .core_finish (core_finish),
    .core_z      (core_z)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [511:0] core_fn(input logic [255:0] m);
    return {m ^ {4{64'h0123_4567_89AB_CDEF}}, ~{m[127:0], m[255:128]}};
  endfunction

  // Core stand-in: finish pulses core_lat cycles after core_active; core_z is junk otherwise.
  initial begin : core_model
    bit armed;
    int cnt;
    logic [255:0] seen_m;
    armed = 1'b0;
    cnt = 0;
    seen_m = '0;
    core_finish = 1'b0;
    core_z = {16{32'hDEAD_BEEF}};
    forever begin
      @(negedge clk);
      core_finish = 1'b0;
      core_z = {16{32'hDEAD_BEEF}};
      if (!rst_n) begin
        armed = 1'b0;
      end else if (core_active === 1'b1) begin
        armed = !core_hang;
        cnt = core_lat;
        seen_m = core_m;
        n_active++;
      end else if (armed) begin
        cnt--;
        if (cnt == 0) begin
          core_finish = 1'b1;
          core_z = core_fn(seen_m);
          armed = 1'b0;
        end
      end
    end
  end

  task automatic wait_active(input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit && t < 0; i++) begin
      @(negedge clk);
      if (core_active === 1'b1) t = cyc;
    end
  endtask

  task automatic wait_done(input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit && t < 0; i++) begin
      @(negedge clk);
      if (done !== 4'b0000) t = cyc;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b0000;
    msg[255:0]   = '0;
    msg[511:256] = {8{32'hA1A1_0001}};
    msg[767:512] = {8{32'hB2B2_0002}};
    msg[1023:768] = {8{32'hC3C3_0003}};
    repeat (3) @(negedge clk);
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL reset_done: got %b want 0000", done); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_tests++; if (digest !== 512'h0) begin n_fail++; $display("FAIL reset_digest: got %h want 0", digest); end
    n_tests++; if (core_m !== 256'h0) begin n_fail++; $display("FAIL reset_core_m: got %h want 0", core_m); end
    n_tests++; if (core_active !== 1'b0) begin n_fail++; $display("FAIL reset_core_active: got %b want 0", core_active); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int t;
    int e;
    logic [3:0] exp_d;
    core_lat = 5;
    core_hang = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(200, t);
      e = k % 4;
      exp_d = 4'b0001 << e;
      n_tests++; if (done !== exp_d) begin n_fail++; $display("FAIL rr_done[%0d]: got %b want %b", k, done, exp_d); end
      n_tests++; if (gnt !== exp_d) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, exp_d); end
      n_tests++; if (digest !== core_fn(msg[e*256 +: 256])) begin n_fail++; $display("FAIL rr_digest[%0d]: got %h want %h", k, digest, core_fn(msg[e*256 +: 256])); end
      n_tests++; if (core_m !== msg[e*256 +: 256]) begin n_fail++; $display("FAIL rr_core_m[%0d]: got %h want %h", k, core_m, msg[e*256 +: 256]); end
      if (k == 4) req = 4'b0000;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    int ta;
    int td;
    int a0;
    core_lat = 30;
    a0 = n_active;
    req = 4'b0001;
    wait_active(50, ta);
    wait_done(200, td);
    n_tests++; if (ta < 0) begin n_fail++; $display("FAIL single_issue: got no core_active want pulse"); end
    n_tests++; if ((td - ta) !== 31) begin n_fail++; $display("FAIL single_latency: got %0d want 31", td - ta); end
    n_tests++; if (done !== 4'b0001) begin n_fail++; $display("FAIL single_done: got %b want 0001", done); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", err); end
    n_tests++; if (digest !== core_fn(256'h0)) begin n_fail++; $display("FAIL single_digest: got %h want %h", digest, core_fn(256'h0)); end
    req = 4'b0000;
    repeat (5) @(negedge clk);
    n_tests++; if ((n_active - a0) !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d want 1", n_active - a0); end
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_gnt_idle: got %b want 0000", gnt); end
  endtask

  task automatic test_timeout();
    int ta;
    int td;
    logic [511:0] dig_before;
    dig_before = digest;
    core_hang = 1'b1;
    req = 4'b0010;
    wait_active(50, ta);
    wait_done(200, td);
    n_tests++; if ((td - ta) !== TMO + 1) begin n_fail++; $display("FAIL tmo_latency: got %0d want %0d", td - ta, TMO + 1); end
    n_tests++; if (done !== 4'b0010) begin n_fail++; $display("FAIL tmo_done: got %b want 0010", done); end
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b want 1", err); end
    n_tests++; if (digest !== dig_before) begin n_fail++; $display("FAIL tmo_digest: got %h want %h", digest, dig_before); end
    req = 4'b0000;
    core_hang = 1'b0;
    core_lat = 5;
    @(negedge clk);
    req = 4'b0100;
    wait_done(200, td);
    n_tests++; if (done !== 4'b0100) begin n_fail++; $display("FAIL tmo_next_done: got %b want 0100", done); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_next_err: got %b want 0", err); end
    n_tests++; if (digest !== core_fn(msg[767:512])) begin n_fail++; $display("FAIL tmo_next_digest: got %h want %h", digest, core_fn(msg[767:512])); end
    req = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_finish_at_expiry();
    int ta;
    int td;
    core_lat = TMO;
    req = 4'b1000;
    wait_active(50, ta);
    wait_done(200, td);
    n_tests++; if ((td - ta) !== TMO + 1) begin n_fail++; $display("FAIL race_latency: got %0d want %0d", td - ta, TMO + 1); end
    n_tests++; if (done !== 4'b1000) begin n_fail++; $display("FAIL race_done: got %b want 1000", done); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL race_err: got %b want 0", err); end
    n_tests++; if (digest !== core_fn(msg[1023:768])) begin n_fail++; $display("FAIL race_digest: got %h want %h", digest, core_fn(msg[1023:768])); end
    req = 4'b0000;
    core_lat = 5;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    int ta;
    int td;
    bit saw_done;
    core_hang = 1'b1;
    req = 4'b0110;
    wait_active(50, ta);
    n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL midrst_pre_gnt: got %b want 0010", gnt); end
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL midrst_gnt: got %b want 0000", gnt); end
    n_tests++; if (digest !== 512'h0) begin n_fail++; $display("FAIL midrst_digest: got %h want 0", digest); end
    n_tests++; if (core_m !== 256'h0) begin n_fail++; $display("FAIL midrst_core_m: got %h want 0", core_m); end
    n_tests++; if ({core_active, err} !== 2'b00) begin n_fail++; $display("FAIL midrst_act_err: got %b want 00", {core_active, err}); end
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done !== 4'b0000) saw_done = 1'b1;
    end
    n_tests++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done: got %b want 0", saw_done); end
    core_hang = 1'b0;
    core_lat = 5;
    req = 4'b1111;
    rst_n = 1'b1;
    wait_done(200, td);
    n_tests++; if (done !== 4'b0001) begin n_fail++; $display("FAIL midrst_first: got %b want 0001", done); end
    req = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_drop_req();
    int ta;
    int td;
    core_lat = 10;
    core_hang = 1'b0;
    req = 4'b0101;
    wait_active(50, ta);
    n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL drop_gnt: got %b want 0100", gnt); end
    repeat (3) @(negedge clk);
    req[2] = 1'b0;
    wait_done(200, td);
    n_tests++; if (done !== 4'b0100) begin n_fail++; $display("FAIL drop_done: got %b want 0100", done); end
    n_tests++; if (digest !== core_fn(msg[767:512])) begin n_fail++; $display("FAIL drop_digest: got %h want %h", digest, core_fn(msg[767:512])); end
    wait_done(200, td);
    n_tests++; if (done !== 4'b0001) begin n_fail++; $display("FAIL drop_next: got %b want 0001", done); end
    wait_done(200, td);
    n_tests++; if (done !== 4'b0001) begin n_fail++; $display("FAIL drop_no_regrant: got %b want 0001", done); end
    req = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_timeout();
    test_finish_at_expiry();
    test_reset_mid_wait();
    test_drop_req();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha3_512_arbiter.md
SHA3_512_ARBITER -- requirements
Module: sha3_512_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one SHA3-512 core.
REQ-002 SHALL have parameter TIMEOUT, default 64: maximum cycles waiting for core finish.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, NREQ bits: per-requester level request, held high until its done pulse.
REQ-006 SHALL have port msg, input, NREQ*256 bits: requester i message at bits [i*256 +: 256].
REQ-007 SHALL have port gnt, output, NREQ bits: one-hot, high for the requester being served, ISSUE through DELIVER.
REQ-008 SHALL have port done, output, NREQ bits: one-cycle pulse to the served requester when service ends.
REQ-009 SHALL have port err, output, 1 bit: asserted together with done when service ended by timeout.
REQ-010 SHALL have port digest, output, 512 bits: last captured core result, held until next capture.
REQ-011 SHALL have port core_m, output, 256 bits: message to core, stable from ISSUE until return to IDLE.
REQ-012 SHALL have port core_active, output, 1 bit: start pulse to core.
REQ-013 SHALL have port core_finish, input, 1 bit: core one-cycle completion pulse; core_z valid in the same cycle.
REQ-014 SHALL have port core_z, input, 512 bits: core digest.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, DELIVER.
REQ-016 IDLE: if any req bit is high, SHALL select a winner round-robin, starting at the index after the last served requester; latch its index and message; go to ISSUE.
REQ-017 ISSUE: SHALL drive core_active=1 for exactly one cycle; SHALL clear the timeout counter; SHALL go to WAIT.
REQ-018 WAIT: on core_finish=1, SHALL capture core_z into digest and go to DELIVER with err flag=0.
REQ-019 WAIT: timeout counter SHALL increment each cycle; when it reaches TIMEOUT-1 without finish, SHALL go to DELIVER with err flag=1 and digest unchanged.
REQ-020 WAIT: if core_finish and timeout expiry coincide, finish SHALL win (err=0, digest captured).
REQ-021 DELIVER: SHALL pulse done[idx]=1 for one cycle, err=flag; update round-robin pointer to idx; return to IDLE.
REQ-022 DELIVER->IDLE SHALL guarantee at least one core-idle cycle between consecutive core_active pulses.
REQ-023 A request is not cancellable: if req[idx] drops during service, service SHALL complete and done SHALL still pulse.
REQ-024 req[idx] still high in the cycle after done SHALL be treated as a new request, arbitrated fairly against others.
REQ-025 req bits changing outside IDLE SHALL have no effect on the current service.
REQ-026 With all NREQ requests held continuously, grants SHALL rotate 0,1,...,NREQ-1,0; no requester waits more than NREQ-1 services.
REQ-027 Pointer and index widths SHALL be clog2(NREQ), minimum 1; NREQ=1 SHALL work.
REQ-028 Timeout counter SHALL be clog2(TIMEOUT)+1 bits and SHALL saturate, never wrap.

Reset
REQ-029 rst_n low SHALL asynchronously force: state IDLE; gnt=0; done=0; err=0; digest=0; core_m=0; core_active=0; timeout counter=0; pointer=NREQ-1, so requester 0 has first priority.
REQ-030 Reset mid-service SHALL abandon the service with no done pulse; the core SHALL be reset in the same domain by the integrator.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (2-bit), message width 256 and digest width 512.
REQ-032 The round-robin selector SHALL be a separate combinational sub-module, rr_pick: inputs req and pointer; outputs found and index.
REQ-033 Outputs done, err, core_active and gnt SHALL be registered.

Verification
REQ-034 Single request: req=0001, msg0=0, core model finishes 30 cycles after core_active -> one core_active pulse, done=0001 at cycle 31, err=0, digest = SHA3-512 of 32 zero bytes.
REQ-035 All four requesters held high -> grant order 0,1,2,3,0; each done pulse carries the digest of that requester's message.
REQ-036 Core never finishes -> done pulses TIMEOUT cycles after WAIT entry with err=1; digest unchanged; next request is served normally.
REQ-037 finish arrives in the timeout-expiry cycle -> err=0, digest captured.
REQ-038 rst_n pulsed low during WAIT -> outputs immediately at reset values, no done pulse; after release, requester 0 has priority.
REQ-039 req[2] dropped during WAIT -> done[2] still pulses; no re-grant to 2 unless req[2] is reasserted.
